// File: rtl/cla_add_pipe.sv
// +----------------------------------------------------------------------------+
// | cla_add_pipe: pipelined carry-lookahead adder/subtractor, valid/ready.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cla_add_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NGRP = WIDTH / GROUP;
    localparam int GPS  = NGRP / PIPE;
    localparam int SW   = GPS * GROUP;

    // Register after stage k-1 (k>=1) packs {carry, b', a, resolved sum} with
    // only the unresolved operand bits kept; the output stage packs {ovf, cout, sum}.
    function automatic int st_w(input int k);
        return 2 * WIDTH - k * SW + 1;
    endfunction

    function automatic int st_off(input int k);
        int o;
        o = 0;
        for (int j = 1; j < k; j++) begin
            o = o + st_w(j);
        end
        return o;
    endfunction

    localparam int FOFF = st_off(PIPE);
    localparam int TOT  = FOFF + WIDTH + 2;

    // One stage worth of lookahead groups; group carries chain from group P/G.
    function automatic logic [SW:0] stage_add(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          ci
    );
        logic [SW-1:0] s;
        logic          cg;
        logic          gp;
        logic          pp;
        logic          p;
        logic          g;
        s  = '0;
        cg = ci;
        for (int j = 0; j < GPS; j++) begin
            gp = 1'b0;
            pp = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                p = x[j*GROUP+i] ^ y[j*GROUP+i];
                g = x[j*GROUP+i] & y[j*GROUP+i];
                s[j*GROUP+i] = p ^ (gp | (pp & cg));
                gp = g | (p & gp);
                pp = pp & p;
            end
            cg = gp | (pp & cg);
        end
        return {cg, s};
    endfunction

    logic [TOT-1:0]  r_pipe;
    logic [TOT-1:0]  w_pipe_nx;
    logic [PIPE-1:0] r_v;
    logic [PIPE-1:0] w_v_nx;
    logic            w_advance;

    assign out_valid = r_v[PIPE-1];
    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance;
    assign sum       = r_pipe[FOFF +: WIDTH];
    assign cout      = r_pipe[FOFF + WIDTH];
    assign ovf       = r_pipe[FOFF + WIDTH + 1];

    for (genvar k = 0; k < PIPE; k++) begin : g_stage
        localparam int LO = k * SW;
        localparam int HI = LO + SW;

        logic [WIDTH-1:LO] w_a_in;
        logic [WIDTH-1:LO] w_b_in;
        logic              w_c_in;
        logic              w_v_in;
        logic [SW:0]       w_res;
        logic [HI-1:0]     w_s_nx;
        logic              w_ld;

        if (k == 0) begin : g_src_port
            assign w_a_in = a;
            assign w_b_in = sub ? ~b : b;
            assign w_c_in = sub | cin;
            assign w_v_in = in_valid;
            assign w_s_nx = w_res[SW-1:0];
        end else begin : g_src_reg
            localparam int OFF = st_off(k);
            assign w_s_nx = {w_res[SW-1:0], r_pipe[OFF +: LO]};
            assign w_a_in = r_pipe[OFF + LO +: WIDTH - LO];
            assign w_b_in = r_pipe[OFF + WIDTH +: WIDTH - LO];
            assign w_c_in = r_pipe[OFF + 2*WIDTH - LO];
            assign w_v_in = r_v[k-1];
        end

        assign w_res     = stage_add(w_a_in[HI-1:LO], w_b_in[HI-1:LO], w_c_in);
        assign w_ld      = w_advance & w_v_in;
        assign w_v_nx[k] = w_advance ? w_v_in : r_v[k];

        if (k < PIPE - 1) begin : g_to_reg
            localparam int OFFN = st_off(k + 1);
            localparam int WN   = st_w(k + 1);
            assign w_pipe_nx[OFFN +: WN] = w_ld
                ? {w_res[SW], w_b_in[WIDTH-1:HI], w_a_in[WIDTH-1:HI], w_s_nx}
                : r_pipe[OFFN +: WN];
        end else begin : g_to_out
            logic w_ovf;
            // Carry into the MSB is recovered as sum ^ p at that bit.
            assign w_ovf = w_s_nx[WIDTH-1] ^ w_a_in[WIDTH-1] ^ w_b_in[WIDTH-1] ^ w_res[SW];
            assign w_pipe_nx[FOFF +: WIDTH+2] = w_ld
                ? {w_ovf, w_res[SW], w_s_nx}
                : r_pipe[FOFF +: WIDTH+2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
            r_v    <= '0;
        end else begin
            r_pipe <= w_pipe_nx;
            r_v    <= w_v_nx;
        end
    end

endmodule

`default_nettype wire
